vga_pmod_tx: RTL and testbench



---
 rtl/vga_pmod_tx.sv | 77 +++++++
 tb/tb_vga_pmod_tx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vga_pmod_tx.sv
// VGA timing generator driving a TinyVGA PMOD: free-running pixel/line counters,
// sync generation and a registered pin output with colour blanking.
module vga_pmod_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_NEG = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] pix_rgb,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_active,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic [7:0] uo_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Idle level of the sync pins; an active raw sync inverts it.
    localparam logic SYNC_IDLE = (SYNC_NEG != 0);

    logic       h_last;
    logic       v_last;
    logic       hsync_raw;
    logic       vsync_raw;
    logic [5:0] rgb;

    always_comb begin
        h_last       = (pix_x == H_LAST);
        v_last       = (pix_y == V_LAST);
        video_active = (pix_x < H_ACT) && (pix_y < V_ACT);
        frame_start  = ena && (pix_x == '0) && (pix_y == '0);
        hsync_raw    = (pix_x >= HS_BEG) && (pix_x <= HS_END);
        vsync_raw    = (pix_y >= VS_BEG) && (pix_y <= VS_END);
        rgb          = video_active ? pix_rgb : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_x     <= '0;
            pix_y     <= '0;
            frame_cnt <= '0;
            uo_out    <= {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};
        end else if (ena) begin
            pix_x <= h_last ? '0 : pix_x + 1'b1;
            if (h_last) begin
                pix_y <= v_last ? '0 : pix_y + 1'b1;
            end
            if (h_last && v_last) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            // pix_rgb is {R1,R0,G1,G0,B1,B0}; pins are {hs,B0,G0,R0,vs,B1,G1,R1}
            uo_out <= {hsync_raw ^ SYNC_IDLE, rgb[0], rgb[2], rgb[4],
                       vsync_raw ^ SYNC_IDLE, rgb[1], rgb[3], rgb[5]};
        end
    end

endmodule

// File: tb/tb_vga_pmod_tx.sv
// Randomized scoreboard bench for vga_pmod_tx using reduced timing so many
// frames fit in a short run; a second instance covers positive sync polarity.
module tb_vga_pmod_tx;

    localparam int HA = 20, HFP = 4, HS = 6, HBP = 5;
    localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int CYCLES = 30000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [5:0] pix_rgb;
    logic [9:0] pix_x, pix_y;
    logic       video_active, frame_start;
    logic [7:0] frame_cnt, uo_out;
    logic [9:0] p_x, p_y;
    logic       p_active, p_fs;
    logic [7:0] p_frame, p_uo;

    always #5 clk = ~clk;

    vga_pmod_tx #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_NEG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pix_rgb(pix_rgb),
        .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
        .frame_start(frame_start), .frame_cnt(frame_cnt), .uo_out(uo_out)
    );

    vga_pmod_tx #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_NEG(0)
    ) dut_pos (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pix_rgb(pix_rgb),
        .pix_x(p_x), .pix_y(p_y), .video_active(p_active),
        .frame_start(p_fs), .frame_cnt(p_frame), .uo_out(p_uo)
    );

    typedef struct {
        int unsigned x;
        int unsigned y;
        int unsigned frame;
        logic        active;
        logic        fs;
        logic [7:0]  uo_neg;
        logic [7:0]  uo_pos;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Pin image for a pixel position, built from the sync windows and colour map.
    function automatic logic [7:0] pins(int unsigned x, int unsigned y,
                                        logic [5:0] rgb, bit neg);
        logic [7:0] u;
        bit hs_on, vs_on, act;
        hs_on = (x >= HA + HFP) && (x < HA + HFP + HS);
        vs_on = (y >= VA + VFP) && (y < VA + VFP + VS);
        act   = (x < HA) && (y < VA);
        u = '0;
        u[7] = neg ? !hs_on : hs_on;
        u[3] = neg ? !vs_on : vs_on;
        if (act) begin
            u[0] = rgb[5]; // R1
            u[4] = rgb[4]; // R0
            u[1] = rgb[3]; // G1
            u[5] = rgb[2]; // G0
            u[2] = rgb[1]; // B1
            u[6] = rgb[0]; // B0
        end
        return u;
    endfunction

    task automatic check(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every clock edge the DUT presents new state; compare with queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pix_x", pix_x, e.x);
                check("pix_y", pix_y, e.y);
                check("frame_cnt", frame_cnt, e.frame);
                check("video_active", video_active, e.active);
                check("frame_start", frame_start, e.fs);
                check("uo_out_neg", uo_out, e.uo_neg);
                check("uo_out_pos", p_uo, e.uo_pos);
                check("pos_counters", {p_x, p_y, p_frame, p_active, p_fs},
                      {pix_x, pix_y, frame_cnt, video_active, frame_start});
            end
        end
    end

    // Driver plus reference model: t counts enabled advances since the last reset.
    initial begin
        int unsigned t = 0;
        int unsigned freeze = 0;
        int unsigned x, y;
        logic [7:0] uo_n = 8'h88;
        logic [7:0] uo_p = 8'h00;
        exp_t e;
        rst_n = 1'b0;
        ena = 1'b0;
        pix_rgb = '0;
        for (int unsigned c = 0; c < CYCLES; c++) begin
            @(negedge clk);
            x = t % HT;
            y = (t / HT) % VT;
            if (c < 3) begin
                rst_n = 1'b0;
                ena = 1'(c == 2);
            end else begin
                rst_n = ($urandom_range(0, 4999) != 0);
                if (freeze != 0) begin
                    freeze--;
                    ena = 1'b0;
                end else if ($urandom_range(0, 399) == 0) begin
                    freeze = 49;
                    ena = 1'b0;
                end else begin
                    ena = ($urandom_range(0, 7) != 0);
                end
            end
            pix_rgb = 6'($urandom);
            if (!rst_n) begin
                t = 0;
                uo_n = 8'h88;
                uo_p = 8'h00;
            end else if (ena) begin
                uo_n = pins(x, y, pix_rgb, 1'b1);
                uo_p = pins(x, y, pix_rgb, 1'b0);
                t++;
            end
            e.x = t % HT;
            e.y = (t / HT) % VT;
            e.frame = (t / FT) % 256;
            e.active = (e.x < HA) && (e.y < VA);
            e.fs = ena && (e.x == 0) && (e.y == 0);
            e.uo_neg = uo_n;
            e.uo_pos = uo_p;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
